// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: opcodes, FSM states and ALU width.
package alu_pkg;

    localparam int ALU_W = 4;

    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_SUB   = 2'b01;
    localparam logic [1:0] OP_SHL_A = 2'b10;
    localparam logic [1:0] OP_SHL_B = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_e;

endpackage

// File: rtl/alu_arbiter_rr_pick.sv
// Combinational round-robin selector: the first asserted request at or after
// ptr_i (wrapping at NREQ) wins.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IW-1:0]   idx_o,
    output logic            any_o
);

    logic [IW:0]   sum;
    logic [IW-1:0] cand;

    // Scan NREQ positions starting at ptr_i; keep the first hit only.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        sum     = '0;
        cand    = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, ptr_i} + (IW+1)'(k);
            if (sum >= (IW+1)'(NREQ)) begin
                sum = sum - (IW+1)'(NREQ);
            end
            cand = sum[IW-1:0];
            if (!any_o && req_i[cand]) begin
                any_o         = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = cand;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external 4-bit combinational ALU among NREQ
// requesters. One transaction in flight: accept in IDLE, hold ALU inputs in
// ISSUE, register the ALU result in CAPTURE, hand it back in RESP.
//
// Handshakes: a request transfers on a cycle where req_valid[i] and
// req_ready[i] are both high; a response transfers on a cycle where
// rsp_valid[i] and rsp_ready[i] are both high. req_ready never depends on
// anything but state, ptr and req_valid; rsp_valid never depends on rsp_ready.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = ALU_W,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    input  logic [NREQ*2-1:0] req_op,
    output logic [NREQ-1:0]   rsp_valid,
    input  logic [NREQ-1:0]   rsp_ready,
    output logic [W-1:0]      rsp_result,
    output logic [W-1:0]      alu_a,
    output logic [W-1:0]      alu_b,
    output logic [1:0]        alu_op,
    input  logic [W-1:0]      alu_result,
    output logic [IW-1:0]     grant_id,
    output logic              busy,
    output logic [1:0]        state_dbg
);

    state_e        state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] grant_q, grant_d;
    logic [W-1:0]  a_q, a_d, b_q, b_d, res_q, res_d;
    logic [1:0]    op_q, op_d;

    logic [NREQ-1:0] pick_oh;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;
    logic [W-1:0]    sel_a, sel_b;
    logic [1:0]      sel_op;

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (pick_oh),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    // Mux the winning requester's operands out of the packed buses.
    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_oh[i]) begin
                sel_a  = req_a[i*W +: W];
                sel_b  = req_b[i*W +: W];
                sel_op = req_op[i*2 +: 2];
            end
        end
    end

    // Next-state and handshake outputs; everything holds unless a state acts.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        res_d     = res_q;
        req_ready = '0;
        rsp_valid = '0;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    req_ready = pick_oh;
                    a_d       = sel_a;
                    b_d       = sel_b;
                    op_d      = sel_op;
                    grant_d   = pick_idx;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                res_d   = alu_result;
                state_d = RESP;
            end
            RESP: begin
                rsp_valid[grant_q] = 1'b1;
                if (rsp_ready[grant_q]) begin
                    // Pointer moves only on completion, to the requester after the winner.
                    ptr_d   = (grant_q == IW'(NREQ-1)) ? '0 : grant_q + IW'(1);
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Nothing is offered or returned while reset is applied.
        if (rst) begin
            req_ready = '0;
            rsp_valid = '0;
        end
    end

    // State and datapath registers; reset drops any in-flight operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
        end
    end

    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_op     = op_q;
    assign rsp_result = res_q;
    assign grant_id   = grant_q;
    assign busy       = (state_q != IDLE);
    assign state_dbg  = state_q;

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

- Shares one 4-bit combinational ALU (ops: add, sub, shift-left a, shift-left b) among NREQ requesters.
- Each request carries operands and an opcode, entered over a valid/ready handshake. A round-robin FSM accepts one request, drives the external ALU datapath, registers the result, and returns it to the winning requester over a response valid/ready handshake.
- Sits between client blocks and the ALU instance, and is the only driver of the ALU's operand and opcode inputs.

## Interface
- NREQ, 4: number of requesters, 2..8.
- W, 4: operand/result width; the ALU is 4-bit, so only W=4 is supported.
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_a  in  NREQ*W  packed operand a; requester i uses bits [i*W +: W].
- req_b  in  NREQ*W  packed operand b.
- req_op  in  NREQ*2  packed opcode: 00 add, 01 sub, 10 a<<1, 11 b<<1.
- rsp_valid  out  NREQ  one-hot response valid to the granted requester.
- rsp_ready  in  NREQ  per-requester response accept.
- rsp_result  out  W  result, shared by all requesters; qualify with rsp_valid.
- alu_a, alu_b  out  W  ALU operand drive, registered.
- alu_op  out  2  ALU opcode drive, registered.
- alu_result  in  W  ALU combinational result.
- grant_id  out  $clog2(NREQ)  index of the current or last granted requester.
- busy  out  1  high in every state except IDLE.

## Operation
- **IDLE**
  - Round-robin pick among req_valid, starting search at ptr.
  - If any is valid: assert req_ready[g] combinationally (one-hot).
  - Latch the requester's a, b, op into alu_a, alu_b, alu_op; set grant_id=g; go to ISSUE.
  - If none is valid: stay in IDLE; req_ready=0.
- **ISSUE**: ALU inputs held stable for one cycle while the combinational ALU settles. Next state is CAPTURE.
- **CAPTURE**: rsp_result <= alu_result. Next state is RESP.
- **RESP**
  - rsp_valid[grant_id]=1; rsp_result held stable.
  - On rsp_ready[grant_id]: ptr <= (grant_id+1) mod NREQ; go to IDLE.
  - rsp_ready of non-granted requesters is ignored.
- **Arithmetic**: modulo 2^W, performed by the ALU, not by this block.
  - Sub wraps, e.g. 2-5=13.
  - Shifts drop the MSB and fill with 0.
- **Ordering**: at most one transaction is in flight; no request is accepted outside IDLE.
- **Request rules**
  - req_valid dropping before acceptance is legal.
  - Operands are sampled only on the accept cycle.

## Timing
- **Reset values**: state=IDLE, ptr=0, req_ready=0, rsp_valid=0, rsp_result=0, alu_a=0, alu_b=0, alu_op=0, grant_id=0, busy=0.
- **Latency**: accept in cycle T; ALU inputs valid from T+1; result registered at end of T+2; rsp_valid high from T+3.
- **Throughput**: one op per 4 cycles minimum, when rsp_ready is already high at T+3.
- **Backpressure**: rsp_valid, rsp_result and grant_id hold until rsp_ready; req_ready stays 0 throughout.
- **Release timing**: IDLE is re-entered the cycle after the response handshake, so a new accept is possible at T+4 at the earliest.
- **Simultaneous requests**: exactly one is granted, by round-robin from ptr. With all requesters held valid, grants cycle 0,1,2,...,NREQ-1,0.
- **Reset mid-transaction**: the in-flight operation is discarded with no response. All outputs and ptr return to reset values at the next edge.
- **Pointer**: ptr advances only on response completion, not on accept.

## Structure
- **Package alu_pkg**
  - Opcode constants OP_ADD=2'b00, OP_SUB=2'b01, OP_SHL_A=2'b10, OP_SHL_B=2'b11.
  - FSM state enum {IDLE, ISSUE, CAPTURE, RESP}.
  - Width constant ALU_W=4.
- **Sub-module rr_pick**
  - Combinational round-robin priority selector.
  - Inputs: req vector, ptr.
  - Outputs: one-hot grant, index, any.
  - Parameterised by NREQ.
- **Integration**: the ALU instance lives outside this block and is connected at the next level up.

## Test plan
- **Reset**: rst high for 2 cycles with req_valid=all ones -> every output at its reset value, req_ready=0 during rst; the first grant after release is requester 0.
- **Add and wrapping sub**
  - Req 0: a=3, b=5, op=00, accepted at T -> rsp_valid[0] at T+3 with rsp_result=8.
  - Then a=2, b=5, op=01 -> 13.
- **Shifts**
  - Requester 1: a=9, op=10 -> 2.
  - Requester 2: b=12, op=11 -> 8.
  - grant_id matches in each case.
- **Fairness**: NREQ=4, all req_valid held high, rsp_ready tied high -> grant order 0,1,2,3,0,1; an accept every 4 cycles.
- **Backpressure**: rsp_ready[0] low for 5 cycles during RESP, with requester 1 valid -> rsp_valid[0] and rsp_result stable, req_ready[1]=0; requester 1 is accepted the cycle after rsp_ready[0] rises and IDLE is re-entered.
- **Reset mid-op**: rst pulsed in CAPTURE for requester 2 -> no rsp_valid[2], busy=0, ptr=0; the next request from requester 2 completes normally.
